// File: rtl/sram16x8_pkg.sv
// Shared constants and encodings for the two-requester SRAM arbiter.
// The state and side encodings are visible to any checker bound to the design.
package sram16x8_pkg;

   localparam int AW = 4;
   localparam int DW = 8;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   typedef enum logic {
      SIDE_A = 1'b0,
      SIDE_B = 1'b1
   } side_t;

endpackage

// File: rtl/sram16x8_rr_arbiter_rr_arb2.sv
// Two-way round-robin grant. rr_ptr names the side that wins the next tie
// and always moves to the side that was not just served.
module rr_arb2
   import sram16x8_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);

   side_t rr_ptr;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (rr_ptr == SIDE_A) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= SIDE_A;
      end else if (gnt[0]) begin
         rr_ptr <= SIDE_B;
      end else if (gnt[1]) begin
         rr_ptr <= SIDE_A;
      end
   end

endmodule

// File: rtl/sram16x8_rr_arbiter.sv
// Shares one 16x8 sync dual-port SRAM between requesters A and B with a
// clear sequencer. Handshake: req_x is valid, fields held until gnt_x; gnt_x
// (combinational) accepts the request in that same cycle; reads return a
// single-cycle rvalid_x one cycle after the grant.
module sram16x8_rr_arbiter
   import sram16x8_pkg::*;
#(
   parameter int AW = sram16x8_pkg::AW,
   parameter int DW = sram16x8_pkg::DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_a,
   input  logic          wr_a,
   input  logic [AW-1:0] addr_a,
   input  logic [DW-1:0] wdata_a,
   output logic          gnt_a,
   output logic          rvalid_a,
   output logic [DW-1:0] rdata_a,
   input  logic          req_b,
   input  logic          wr_b,
   input  logic [AW-1:0] addr_b,
   input  logic [DW-1:0] wdata_b,
   output logic          gnt_b,
   output logic          rvalid_b,
   output logic [DW-1:0] rdata_b,
   input  logic          clr_req,
   output logic          clr_done,
   output logic          mem_rst,
   output logic          mem_we,
   output logic          mem_en,
   output logic [AW-1:0] mem_w_addr,
   output logic [AW-1:0] mem_r_addr,
   output logic [DW-1:0] mem_data_w,
   input  logic [DW-1:0] mem_data_r
);

   state_t     state;
   state_t     state_nxt;
   logic       arb_en;
   logic [1:0] gnt;
   logic       rd_gnt;
   logic       pend_valid;
   side_t      pend_side;

   rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req ({req_b, req_a}),
      .en  (arb_en),
      .gnt (gnt)
   );

   // Clear wins over any pending request; CLEAR always lasts exactly one cycle.
   always_comb begin
      state_nxt = state;
      arb_en    = 1'b0;
      mem_rst   = 1'b0;
      case (state)
         ST_CLEAR: begin
            mem_rst   = 1'b1;
            state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (clr_req) begin
               state_nxt = ST_CLEAR;
            end else begin
               arb_en = 1'b1;
            end
         end
         default: state_nxt = ST_CLEAR;
      endcase
   end

   always_comb begin
      mem_we     = 1'b0;
      mem_en     = 1'b0;
      mem_w_addr = '0;
      mem_r_addr = '0;
      mem_data_w = '0;
      rd_gnt     = 1'b0;
      if (gnt[0]) begin
         if (wr_a) begin
            mem_we     = 1'b1;
            mem_w_addr = addr_a;
            mem_data_w = wdata_a;
         end else begin
            mem_en     = 1'b1;
            mem_r_addr = addr_a;
            rd_gnt     = 1'b1;
         end
      end else if (gnt[1]) begin
         if (wr_b) begin
            mem_we     = 1'b1;
            mem_w_addr = addr_b;
            mem_data_w = wdata_b;
         end else begin
            mem_en     = 1'b1;
            mem_r_addr = addr_b;
            rd_gnt     = 1'b1;
         end
      end
   end

   // A read issued just before a clear still returns its pre-clear data.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_CLEAR;
         pend_valid <= 1'b0;
         pend_side  <= SIDE_A;
         clr_done   <= 1'b0;
      end else begin
         state      <= state_nxt;
         pend_valid <= rd_gnt;
         pend_side  <= gnt[1] ? SIDE_B : SIDE_A;
         clr_done   <= (state == ST_CLEAR);
      end
   end

   assign gnt_a    = gnt[0];
   assign gnt_b    = gnt[1];
   assign rvalid_a = pend_valid && (pend_side == SIDE_A);
   assign rvalid_b = pend_valid && (pend_side == SIDE_B);
   assign rdata_a  = mem_data_r;
   assign rdata_b  = mem_data_r;

endmodule

// File: tb/tb_sram16x8_rr_arbiter.sv
// Bench for sram16x8_rr_arbiter: directed vector table, reset corner case,
// then random A/B traffic checked against a cycle model and a 16x8 array.
module tb_sram16x8_rr_arbiter;

   typedef struct {
      logic       req_a;
      logic       wr_a;
      logic [3:0] addr_a;
      logic [7:0] wdata_a;
      logic       req_b;
      logic       wr_b;
      logic [3:0] addr_b;
      logic [7:0] wdata_b;
      logic       clr_req;
      logic       gnt_a;
      logic       gnt_b;
      logic       rvalid_a;
      logic       rvalid_b;
      logic [7:0] rdata;
      logic       mem_rst;
      logic       clr_done;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       req_a, wr_a, req_b, wr_b, clr_req;
   logic [3:0] addr_a, addr_b;
   logic [7:0] wdata_a, wdata_b;
   logic       gnt_a, gnt_b, rvalid_a, rvalid_b, clr_done;
   logic [7:0] rdata_a, rdata_b;
   logic       mem_rst, mem_we, mem_en;
   logic [3:0] mem_w_addr, mem_r_addr;
   logic [7:0] mem_data_w, mem_data_r;

   logic [7:0] sram [16];

   int n_checks = 0;
   int n_err    = 0;

   // reference model state
   int         m_state;
   int         m_ptr;
   logic       m_pend_valid;
   logic       m_clr_done;
   logic [7:0] m_mem [16];
   logic [8:0] exp_q [$];
   logic       m_last_ga, m_last_gb;
   int         wait_a, wait_b;

   vec_t tbl [22];

   sram16x8_rr_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req_a      (req_a),
      .wr_a       (wr_a),
      .addr_a     (addr_a),
      .wdata_a    (wdata_a),
      .gnt_a      (gnt_a),
      .rvalid_a   (rvalid_a),
      .rdata_a    (rdata_a),
      .req_b      (req_b),
      .wr_b       (wr_b),
      .addr_b     (addr_b),
      .wdata_b    (wdata_b),
      .gnt_b      (gnt_b),
      .rvalid_b   (rvalid_b),
      .rdata_b    (rdata_b),
      .clr_req    (clr_req),
      .clr_done   (clr_done),
      .mem_rst    (mem_rst),
      .mem_we     (mem_we),
      .mem_en     (mem_en),
      .mem_w_addr (mem_w_addr),
      .mem_r_addr (mem_r_addr),
      .mem_data_w (mem_data_w),
      .mem_data_r (mem_data_r)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural sync dual-port SRAM attached to the mem_* pins
   always @(posedge clk) begin
      if (mem_rst) begin
         for (int i = 0; i < 16; i++) sram[i] <= 8'h00;
         mem_data_r <= 8'h00;
      end else begin
         if (mem_we) sram[mem_w_addr] <= mem_data_w;
         if (mem_en) mem_data_r <= sram[mem_r_addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state      = 0;
      m_ptr        = 0;
      m_pend_valid = 1'b0;
      m_clr_done   = 1'b0;
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      exp_q.delete();
      wait_a = 0;
      wait_b = 0;
   endtask

   function automatic vec_t mk(input logic ra, input logic wa, input logic [3:0] aa,
                               input logic [7:0] da, input logic rb, input logic wb,
                               input logic [3:0] ab, input logic [7:0] db, input logic clr,
                               input logic ga, input logic gb, input logic va, input logic vb,
                               input logic [7:0] rd, input logic mr, input logic cd);
      vec_t v;
      v.req_a = ra; v.wr_a = wa; v.addr_a = aa; v.wdata_a = da;
      v.req_b = rb; v.wr_b = wb; v.addr_b = ab; v.wdata_b = db;
      v.clr_req = clr;
      v.gnt_a = ga; v.gnt_b = gb; v.rvalid_a = va; v.rvalid_b = vb;
      v.rdata = rd; v.mem_rst = mr; v.clr_done = cd;
      return v;
   endfunction

   // driver + checker for one cycle: drive at negedge, check at negedge+1,
   // then advance the model to what the next posedge should commit
   task automatic step(input logic r, input vec_t v, input bit use_tbl);
      logic       ea, eb, e_we, e_en, rd_side;
      logic [3:0] e_wa, e_ra;
      logic [7:0] e_wd, rd_data;
      logic [8:0] e;
      @(negedge clk);
      rst     = r;
      req_a   = v.req_a;  wr_a = v.wr_a;  addr_a = v.addr_a;  wdata_a = v.wdata_a;
      req_b   = v.req_b;  wr_b = v.wr_b;  addr_b = v.addr_b;  wdata_b = v.wdata_b;
      clr_req = v.clr_req;
      #1;
      ea = 1'b0; eb = 1'b0;
      if (m_state == 1 && !v.clr_req) begin
         if (v.req_a && v.req_b) begin
            ea = (m_ptr == 0);
            eb = (m_ptr == 1);
         end else begin
            ea = v.req_a;
            eb = v.req_b;
         end
      end
      e_we = 1'b0; e_en = 1'b0; e_wa = 4'h0; e_ra = 4'h0; e_wd = 8'h00;
      if (ea) begin
         if (v.wr_a) begin e_we = 1'b1; e_wa = v.addr_a; e_wd = v.wdata_a; end
         else begin e_en = 1'b1; e_ra = v.addr_a; end
      end else if (eb) begin
         if (v.wr_b) begin e_we = 1'b1; e_wa = v.addr_b; e_wd = v.wdata_b; end
         else begin e_en = 1'b1; e_ra = v.addr_b; end
      end
      chk("gnt_a", gnt_a, ea);
      chk("gnt_b", gnt_b, eb);
      chk("mem_we", mem_we, e_we);
      chk("mem_en", mem_en, e_en);
      chk("mem_w_addr", mem_w_addr, e_wa);
      chk("mem_r_addr", mem_r_addr, e_ra);
      chk("mem_data_w", mem_data_w, e_wd);
      chk("mem_rst", mem_rst, (m_state == 0));
      chk("clr_done", clr_done, m_clr_done);
      chk("we_en_exclusive", mem_we & mem_en, 1'b0);
      chk("single_grant", gnt_a & gnt_b, 1'b0);
      if (m_pend_valid && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         rd_side = e[8];
         rd_data = e[7:0];
         chk("rvalid_a", rvalid_a, !rd_side);
         chk("rvalid_b", rvalid_b, rd_side);
         if (rd_side) chk("rdata_b", rdata_b, rd_data);
         else         chk("rdata_a", rdata_a, rd_data);
      end else begin
         chk("rvalid_a", rvalid_a, 1'b0);
         chk("rvalid_b", rvalid_b, 1'b0);
      end
      if (use_tbl) begin
         chk("tbl_gnt_a", gnt_a, v.gnt_a);
         chk("tbl_gnt_b", gnt_b, v.gnt_b);
         chk("tbl_rvalid_a", rvalid_a, v.rvalid_a);
         chk("tbl_rvalid_b", rvalid_b, v.rvalid_b);
         chk("tbl_mem_rst", mem_rst, v.mem_rst);
         chk("tbl_clr_done", clr_done, v.clr_done);
         if (v.rvalid_a) chk("tbl_rdata_a", rdata_a, v.rdata);
         if (v.rvalid_b) chk("tbl_rdata_b", rdata_b, v.rdata);
      end
      // starvation bound: a waiting side is passed over at most once
      if (v.req_a && gnt_b) wait_a++;
      if (gnt_a) wait_a = 0;
      if (v.req_b && gnt_a) wait_b++;
      if (gnt_b) wait_b = 0;
      if (v.req_a) chk("wait_a_bound", (wait_a > 1), 1'b0);
      if (v.req_b) chk("wait_b_bound", (wait_b > 1), 1'b0);

      if (ea) begin
         if (v.wr_a) m_mem[v.addr_a] = v.wdata_a;
         else exp_q.push_back({1'b0, m_mem[v.addr_a]});
      end else if (eb) begin
         if (v.wr_b) m_mem[v.addr_b] = v.wdata_b;
         else exp_q.push_back({1'b1, m_mem[v.addr_b]});
      end
      m_pend_valid = (ea && !v.wr_a) || (eb && !v.wr_b);
      m_clr_done   = (m_state == 0);
      if (m_state == 0) begin
         for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
         m_state = 1;
      end else if (v.clr_req) begin
         m_state = 0;
      end
      if (ea) m_ptr = 1;
      else if (eb) m_ptr = 0;
      m_last_ga = ea;
      m_last_gb = eb;
      if (r) model_reset();
   endtask

   initial begin : main
      vec_t idle;
      vec_t v;
      logic       pa, pa_wr, pb, pb_wr;
      logic [3:0] pa_addr, pb_addr;
      logic [7:0] pa_data, pb_data;

      idle = mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0, 0,0,0,0,8'h00,0,0);
      //             ra wa aa    da     rb wb ab    db     clr ga gb va vb rd    mr cd
      tbl[0]  = mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0,  0,0,0,0,8'h00, 1,0);
      tbl[1]  = mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0,  0,0,0,0,8'h00, 0,1);
      tbl[2]  = mk(1,1,4'h3,8'hA5, 0,0,4'h0,8'h00, 0,  1,0,0,0,8'h00, 0,0);
      tbl[3]  = mk(1,0,4'h3,8'h00, 0,0,4'h0,8'h00, 0,  1,0,0,0,8'h00, 0,0);
      tbl[4]  = mk(0,0,4'h0,8'h00, 1,1,4'h2,8'h22, 0,  0,1,1,0,8'hA5, 0,0);
      tbl[5]  = mk(1,1,4'h1,8'h11, 0,0,4'h0,8'h00, 0,  1,0,0,0,8'h00, 0,0);
      tbl[6]  = mk(0,0,4'h0,8'h00, 1,0,4'h0,8'h00, 0,  0,1,0,0,8'h00, 0,0);
      tbl[7]  = mk(1,0,4'h1,8'h00, 1,0,4'h2,8'h00, 0,  1,0,0,1,8'h00, 0,0);
      tbl[8]  = mk(1,0,4'h1,8'h00, 1,0,4'h2,8'h00, 0,  0,1,1,0,8'h11, 0,0);
      tbl[9]  = mk(1,0,4'h1,8'h00, 1,0,4'h2,8'h00, 0,  1,0,0,1,8'h22, 0,0);
      tbl[10] = mk(1,0,4'h1,8'h00, 1,0,4'h2,8'h00, 0,  0,1,1,0,8'h11, 0,0);
      tbl[11] = mk(0,0,4'h0,8'h00, 1,1,4'h5,8'h3C, 1,  0,0,0,1,8'h22, 0,0);
      tbl[12] = mk(0,0,4'h0,8'h00, 1,1,4'h5,8'h3C, 0,  0,0,0,0,8'h00, 1,0);
      tbl[13] = mk(0,0,4'h0,8'h00, 1,1,4'h5,8'h3C, 0,  0,1,0,0,8'h00, 0,1);
      tbl[14] = mk(1,0,4'h5,8'h00, 0,0,4'h0,8'h00, 0,  1,0,0,0,8'h00, 0,0);
      tbl[15] = mk(1,0,4'h3,8'h00, 0,0,4'h0,8'h00, 0,  1,0,1,0,8'h3C, 0,0);
      tbl[16] = mk(1,1,4'h7,8'h77, 0,0,4'h0,8'h00, 0,  1,0,1,0,8'h00, 0,0);
      tbl[17] = mk(1,0,4'h7,8'h00, 0,0,4'h0,8'h00, 0,  1,0,0,0,8'h00, 0,0);
      // read granted right before clr_req: its data is the pre-clear value
      tbl[18] = mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 1,  0,0,1,0,8'h77, 0,0);
      tbl[19] = mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0,  0,0,0,0,8'h00, 1,0);
      tbl[20] = mk(1,0,4'h7,8'h00, 0,0,4'h0,8'h00, 0,  1,0,0,0,8'h00, 0,1);
      tbl[21] = mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0,  0,0,1,0,8'h00, 0,0);

      rst = 1'b1;
      req_a = 0; wr_a = 0; addr_a = 0; wdata_a = 0;
      req_b = 0; wr_b = 0; addr_b = 0; wdata_b = 0;
      clr_req = 0;
      @(posedge clk);
      model_reset();
      step(1'b1, idle, 1'b0);

      for (int i = 0; i < 22; i++) step(1'b0, tbl[i], 1'b1);

      // reset mid-operation drops the pending read and returns rr_ptr to A
      step(1'b0, mk(1,0,4'h7,8'h00, 0,0,4'h0,8'h00, 0, 0,0,0,0,8'h00,0,0), 1'b0);
      step(1'b1, idle, 1'b0);
      chk("rst_cycle_rvalid_a", rvalid_a, 1'b1);
      v = mk(1,0,4'h1,8'h00, 1,0,4'h2,8'h00, 0, 0,0,0,0,8'h00,0,0);
      step(1'b0, v, 1'b0);
      chk("rst_rvalid_dropped", rvalid_a | rvalid_b, 1'b0);
      chk("rst_clear_state", mem_rst, 1'b1);
      step(1'b0, v, 1'b0);
      chk("rst_ptr_a_wins", {gnt_b, gnt_a}, 2'b01);
      step(1'b0, v, 1'b0);
      chk("rst_ptr_then_b", {gnt_b, gnt_a}, 2'b10);
      step(1'b0, idle, 1'b0);

      pa = 1'b0; pb = 1'b0;
      pa_wr = 0; pb_wr = 0; pa_addr = 0; pb_addr = 0; pa_data = 0; pb_data = 0;
      for (int c = 0; c < 2000; c++) begin
         if (!pa && $urandom_range(0, 3) != 0) begin
            pa = 1'b1;
            pa_wr = 1'($urandom_range(0, 1));
            pa_addr = 4'($urandom_range(0, 15));
            pa_data = 8'($urandom_range(0, 255));
         end
         if (!pb && $urandom_range(0, 3) != 0) begin
            pb = 1'b1;
            pb_wr = 1'($urandom_range(0, 1));
            pb_addr = 4'($urandom_range(0, 15));
            pb_data = 8'($urandom_range(0, 255));
         end
         v = mk(pa, pa_wr, pa_addr, pa_data, pb, pb_wr, pb_addr, pb_data,
                ($urandom_range(0, 63) == 0), 0,0,0,0,8'h00,0,0);
         step(1'b0, v, 1'b0);
         if (m_last_ga) pa = 1'b0;
         if (m_last_gb) pb = 1'b0;
      end
      repeat (4) step(1'b0, idle, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
